// File: rtl/write_master_slave.sv
// write_master_slave: AXI3-style write path. A write master turns a user write
// request into one AW transfer, WLEN+1 W beats and one B response; a write
// slave accepts those channels and presents each beat to a simple memory-write
// backend as data plus byte address. Key channel handshakes are exported.
module write_master_slave (
    input  logic        ACLK,
    input  logic        ARESETn,      // active-high synchronous reset despite the name
    input  logic        devclock,     // unused; all logic runs on ACLK
    input  logic        memoryWrite,
    input  logic [31:0] Datain,
    input  logic [31:0] WADDR,
    input  logic [3:0]  ID,
    input  logic [3:0]  WLEN,
    input  logic [2:0]  WSIZE,
    input  logic [1:0]  WBURST,
    input  logic [1:0]  WLOCK,
    input  logic [3:0]  WCACHE,
    input  logic [2:0]  WPROT,
    output logic [1:0]  response,
    input  logic        finishwrite,
    output logic [31:0] Dataout,
    output logic [31:0] addressout,
    output logic        writeavail,
    output logic        AWVALID,
    output logic        AWREADY,
    output logic        WVALID,
    output logic        WREADY,
    output logic        WLAST,
    output logic        BVALID,
    output logic        BREADY
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {M_IDLE, M_ADDR, M_DATA, M_RESP} m_state_t;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} s_state_t;

    // ------------------------------------------------------------------
    // Internal AW/W/B channels between master and slave
    // ------------------------------------------------------------------
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid, awlen, awcache;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wid, wstrb;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic [1:0]  bresp;

    // ------------------------------------------------------------------
    // Master
    // ------------------------------------------------------------------
    m_state_t m_state, m_next;
    logic     mw_q;
    logic     mw_rise;
    logic [3:0] m_cnt;

    assign mw_rise = memoryWrite & ~mw_q;
    assign wdata   = Datain;
    assign wid     = awid;
    assign wstrb   = 4'hF;

    // Master next-state and channel outputs
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        m_next  = m_state;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        case (m_state)
            M_IDLE: if (mw_rise) m_next = M_ADDR;
            M_ADDR: begin
                awvalid = 1'b1;
                if (awready) m_next = M_DATA;
            end
            M_DATA: begin
                wvalid = 1'b1;
                wlast  = (m_cnt == awlen);
                if (wready && wlast) m_next = M_RESP;
            end
            M_RESP: begin
                bready = 1'b1;
                if (bvalid) m_next = M_IDLE;
            end
            default: m_next = M_IDLE;
        endcase
    end

    // Master state, request latch, beat counter and response capture
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            m_state  <= M_IDLE;
            mw_q     <= 1'b0;
            m_cnt    <= 4'd0;
            awaddr   <= 32'd0;
            awid     <= 4'd0;
            awlen    <= 4'd0;
            awsize   <= 3'd0;
            awburst  <= 2'd0;
            awlock   <= 2'd0;
            awcache  <= 4'd0;
            awprot   <= 3'd0;
            response <= RESP_OKAY;
        end else begin
            m_state <= m_next;
            mw_q    <= memoryWrite;
            if (m_state == M_IDLE && mw_rise) begin
                awaddr  <= WADDR;
                awid    <= ID;
                awlen   <= WLEN;
                awsize  <= WSIZE;
                awburst <= WBURST;
                awlock  <= WLOCK;
                awcache <= WCACHE;
                awprot  <= WPROT;
                m_cnt   <= 4'd0;
            end
            if (wvalid && wready) m_cnt <= m_cnt + 4'd1;
            if (bvalid && bready) response <= bresp;
        end
    end

    // ------------------------------------------------------------------
    // Slave
    // ------------------------------------------------------------------
    s_state_t    s_state, s_next;
    logic [3:0]  s_id, s_len, s_cnt;
    logic [2:0]  s_size;
    logic [1:0]  s_burst;
    logic [31:0] s_addr;
    logic        s_err;
    logic [31:0] s_step, wrap_mask, incr_addr, next_addr;
    logic        last_beat, beat_err;

    // AWREADY is held low while reset is asserted so no address is accepted then
    assign awready   = (s_state == S_IDLE) && !ARESETn;
    assign wready    = (s_state == S_DATA) && finishwrite;
    assign bvalid    = (s_state == S_RESP);
    assign bid       = s_id;
    assign bresp     = s_err ? RESP_SLVERR : RESP_OKAY;
    assign last_beat = (s_cnt == s_len);
    assign beat_err  = (wid != s_id) || (wlast != last_beat);

    // Slave next-state
    always_comb begin
        s_next = s_state;
        case (s_state)
            S_IDLE: if (awvalid) s_next = S_DATA;
            S_DATA: if (wvalid && wready && last_beat) s_next = S_RESP;
            S_RESP: if (bready) s_next = S_IDLE;
            default: s_next = S_IDLE;
        endcase
    end

    // Address of the beat after the current one; the wrap window is
    // (len+1)*step bytes aligned to its own size
    always_comb begin
        s_step    = 32'd1 << s_size;
        wrap_mask = (({28'd0, s_len} + 32'd1) << s_size) - 32'd1;
        incr_addr = s_addr + s_step;
        case (s_burst)
            BURST_FIXED: next_addr = s_addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (s_addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;   // reserved encoding behaves as INCR
        endcase
    end

    // Slave state, address latch, beat tracking and backend outputs
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            s_state    <= S_IDLE;
            s_id       <= 4'd0;
            s_len      <= 4'd0;
            s_size     <= 3'd0;
            s_burst    <= 2'd0;
            s_cnt      <= 4'd0;
            s_addr     <= 32'd0;
            s_err      <= 1'b0;
            Dataout    <= 32'd0;
            addressout <= 32'd0;
            writeavail <= 1'b0;
        end else begin
            s_state    <= s_next;
            writeavail <= 1'b0;
            if (awvalid && awready) begin
                s_id    <= awid;
                s_len   <= awlen;
                s_size  <= awsize;
                s_burst <= awburst;
                s_addr  <= awaddr;
                s_cnt   <= 4'd0;
                s_err   <= 1'b0;
            end
            if (wvalid && wready) begin
                Dataout    <= wdata;
                addressout <= s_addr;
                writeavail <= 1'b1;
                s_addr     <= next_addr;
                s_cnt      <= s_cnt + 4'd1;
                if (beat_err) s_err <= 1'b1;
            end
        end
    end

    // Channel monitors
    assign AWVALID = awvalid;
    assign AWREADY = awready;
    assign WVALID  = wvalid;
    assign WREADY  = wready;
    assign WLAST   = wlast;
    assign BVALID  = bvalid;
    assign BREADY  = bready;

    // Fields carried on the channels that the memory backend has no use for
    logic unused_ok;
    assign unused_ok = ^{devclock, awlock, awcache, awprot, wstrb, bid};

endmodule

// File: tb/tb_write_master_slave.sv
// tb_write_master_slave: randomized self-checking bench for write_master_slave.
// Expected beat addresses/data come from an arithmetic model of the burst rules.
module tb_write_master_slave;

    logic        ACLK, ARESETn, devclock, memoryWrite, finishwrite;
    logic [31:0] Datain, WADDR;
    logic [3:0]  ID, WLEN, WCACHE;
    logic [2:0]  WSIZE, WPROT;
    logic [1:0]  WBURST, WLOCK;
    logic [1:0]  response;
    logic [31:0] Dataout, addressout;
    logic        writeavail, AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;

    int checks = 0;
    int errors = 0;
    logic [63:0] mon_q[$];   // {Dataout, addressout} per writeavail pulse

    write_master_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .devclock(devclock),
        .memoryWrite(memoryWrite), .Datain(Datain), .WADDR(WADDR), .ID(ID),
        .WLEN(WLEN), .WSIZE(WSIZE), .WBURST(WBURST), .WLOCK(WLOCK),
        .WCACHE(WCACHE), .WPROT(WPROT), .response(response),
        .finishwrite(finishwrite), .Dataout(Dataout), .addressout(addressout),
        .writeavail(writeavail), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .BVALID(BVALID),
        .BREADY(BREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    initial devclock = 1'b0;
    always #7 devclock = ~devclock;

    // Backend monitor, sampled on the falling edge
    always @(negedge ACLK) begin
        if (writeavail === 1'b1) mon_q.push_back({Dataout, addressout});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte address of beat 'beat' of a burst, from the burst rules
    function automatic logic [31:0] model_addr(input logic [31:0] start, input int beat,
                                               input int len, input int size,
                                               input logic [1:0] burst);
        longint step, window, base, off;
        step = longint'(1) << size;
        case (burst)
            2'b00: return start;
            2'b10: begin
                window = longint'(len + 1) * step;
                base   = longint'(start) - (longint'(start) % window);
                off    = (longint'(start) - base + longint'(beat) * step) % window;
                return 32'(base + off);
            end
            default: return 32'(longint'(start) + longint'(beat) * step);
        endcase
    endfunction

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // One full burst with optional random and scheduled backpressure
    task automatic run_burst(input string name, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int stall_pct, input int stall_beat, input int stall_cycles,
                             input bit fixed_data, input logic [31:0] data_val);
        logic [31:0] exp_data[$];
        logic [31:0] exp_addr[$];
        logic [63:0] e;
        logic [31:0] d;
        int beats, cyc, stalled;
        bit fw, prev_fw;
        mon_q.delete();
        WADDR = addr; WLEN = len; WSIZE = size; WBURST = burst;
        ID = 4'($urandom_range(15)); WLOCK = 2'($urandom_range(3));
        WCACHE = 4'($urandom_range(15)); WPROT = 3'($urandom_range(7));
        finishwrite = 1'b1;
        Datain = fixed_data ? data_val : $urandom;
        memoryWrite = 1'b1;
        tick();                        // request sampled at edge k
        memoryWrite = 1'b0;
        checks++;
        if (AWVALID !== 1'b1 || AWREADY !== 1'b1)
            begin errors++; $display("FAIL %s aw: AWVALID=%b AWREADY=%b want 1 1", name, AWVALID, AWREADY); end
        tick();                        // address handshake at edge k+1
        beats = 0; cyc = 0; stalled = 0; prev_fw = 1'b0;
        while (beats <= int'(len) && cyc < 400) begin
            if (beats == stall_beat && stalled < stall_cycles) begin
                fw = 1'b0; stalled++;
            end else begin
                fw = ($urandom_range(99) >= stall_pct);
            end
            d = fixed_data ? data_val : $urandom;
            finishwrite = fw; Datain = d;
            #1;
            checks++;
            if (WVALID !== 1'b1 || WREADY !== fw || WLAST !== (beats == int'(len)) ||
                BVALID !== 1'b0 || writeavail !== prev_fw)
                begin errors++; $display("FAIL %s data beat %0d: WVALID=%b WREADY=%b WLAST=%b BVALID=%b writeavail=%b want 1 %b %b 0 %b",
                      name, beats, WVALID, WREADY, WLAST, BVALID, writeavail, fw, (beats == int'(len)), prev_fw); end
            if (fw) begin
                exp_data.push_back(d);
                exp_addr.push_back(model_addr(addr, beats, int'(len), int'(size), burst));
                beats++;
            end
            prev_fw = fw;
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 400) begin errors++; $display("FAIL %s timeout: beats=%0d want %0d", name, beats, int'(len) + 1); end
        finishwrite = 1'b1;
        checks++;
        if (BVALID !== 1'b1 || BREADY !== 1'b1 || writeavail !== 1'b1)
            begin errors++; $display("FAIL %s resp: BVALID=%b BREADY=%b writeavail=%b want 1 1 1", name, BVALID, BREADY, writeavail); end
        tick();
        checks++;
        if (BVALID !== 1'b0 || AWVALID !== 1'b0 || WVALID !== 1'b0 || response !== 2'b00 || writeavail !== 1'b0)
            begin errors++; $display("FAIL %s idle: BVALID=%b AWVALID=%b WVALID=%b response=%b writeavail=%b want 0 0 0 00 0",
                  name, BVALID, AWVALID, WVALID, response, writeavail); end
        checks++;
        if (mon_q.size() != exp_data.size())
            begin errors++; $display("FAIL %s pulse count: got %0d want %0d", name, mon_q.size(), exp_data.size()); end
        else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                e = mon_q[i];
                checks++;
                if (e[63:32] !== exp_data[i] || e[31:0] !== exp_addr[i])
                    begin errors++; $display("FAIL %s beat %0d: data=%h addr=%h want data=%h addr=%h",
                          name, i, e[63:32], e[31:0], exp_data[i], exp_addr[i]); end
            end
        end
    endtask

    task automatic test_reset;
        ARESETn = 1'b1; memoryWrite = 1'b0; finishwrite = 1'b0; Datain = 32'd0;
        WADDR = 32'd0; ID = 4'd0; WLEN = 4'd0; WSIZE = 3'd0; WBURST = 2'd0;
        WLOCK = 2'd0; WCACHE = 4'd0; WPROT = 3'd0;
        repeat (3) tick();
        checks++;
        if ({response, Dataout, addressout, writeavail, AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY} !== 75'd0)
            begin errors++; $display("FAIL reset outputs: resp=%b dout=%h aout=%h wa=%b aw=%b%b w=%b%b%b b=%b%b want all 0",
                  response, Dataout, addressout, writeavail, AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY); end
        ARESETn = 1'b0;
        #1;
        checks++;
        if (AWREADY !== 1'b1 || AWVALID !== 1'b0)
            begin errors++; $display("FAIL reset release: AWREADY=%b AWVALID=%b want 1 0", AWREADY, AWVALID); end
    endtask

    task automatic test_fixed;
        run_burst("fixed", 32'd2, 4'd3, 3'd2, 2'b00, 0, -1, 0, 1'b1, 32'd1);
    endtask

    task automatic test_incr_wrap;
        run_burst("incr", 32'h100, 4'd3, 3'd2, 2'b01, 0, -1, 0, 1'b0, 32'd0);
        run_burst("wrap", 32'h108, 4'd3, 3'd2, 2'b10, 0, -1, 0, 1'b0, 32'd0);
        run_burst("incr_rollover", 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01, 0, -1, 0, 1'b0, 32'd0);
        run_burst("wrap16", 32'h2034, 4'd15, 3'd0, 2'b10, 0, -1, 0, 1'b0, 32'd0);
    endtask

    task automatic test_backpressure;
        run_burst("backpressure", 32'h400, 4'd3, 3'd2, 2'b01, 0, 2, 5, 1'b0, 32'd0);
    endtask

    task automatic test_back_to_back;
        logic [63:0] e0, e1;
        mon_q.delete();
        WADDR = 32'h40; WLEN = 4'd0; WSIZE = 3'd2; WBURST = 2'b01; finishwrite = 1'b1;
        for (int c = 0; c < 14; c++) begin
            memoryWrite = (c == 0 || c == 3 || c == 6);
            Datain = (c < 3) ? 32'd1 : (c < 6) ? 32'd2 : 32'd3;
            tick();
        end
        memoryWrite = 1'b0;
        tick();
        checks++;
        if (mon_q.size() != 2)
            begin errors++; $display("FAIL back_to_back count: got %0d want 2", mon_q.size()); end
        else begin
            e0 = mon_q[0]; e1 = mon_q[1];
            checks++;
            if (e0 !== {32'd1, 32'h40} || e1 !== {32'd3, 32'h40})
                begin errors++; $display("FAIL back_to_back data: got %h %h want %h %h", e0, e1, {32'd1, 32'h40}, {32'd3, 32'h40}); end
        end
        checks++;
        if (response !== 2'b00 || AWVALID !== 1'b0)
            begin errors++; $display("FAIL back_to_back idle: response=%b AWVALID=%b want 00 0", response, AWVALID); end
    endtask

    task automatic test_held;
        mon_q.delete();
        WADDR = 32'h80; WLEN = 4'd1; WSIZE = 3'd2; WBURST = 2'b01; finishwrite = 1'b1;
        memoryWrite = 1'b1;
        repeat (16) tick();
        memoryWrite = 1'b0;
        repeat (2) tick();
        checks++;
        if (mon_q.size() != 2)
            begin errors++; $display("FAIL held_request count: got %0d want 2", mon_q.size()); end
    endtask

    task automatic test_reset_mid_burst;
        bit bv;
        WADDR = 32'h200; WLEN = 4'd7; WSIZE = 3'd2; WBURST = 2'b01;
        finishwrite = 1'b1; Datain = $urandom; memoryWrite = 1'b1;
        tick();
        memoryWrite = 1'b0;
        repeat (4) tick();
        checks++;
        if (WVALID !== 1'b1)
            begin errors++; $display("FAIL midreset pre: WVALID=%b want 1", WVALID); end
        ARESETn = 1'b1;
        tick();
        checks++;
        if ({AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, writeavail, response, Dataout, addressout} !== 73'd0)
            begin errors++; $display("FAIL midreset outputs: aw=%b%b w=%b%b b=%b%b wa=%b resp=%b dout=%h aout=%h want all 0",
                  AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, writeavail, response, Dataout, addressout); end
        ARESETn = 1'b0;
        #1;
        checks++;
        if (AWREADY !== 1'b1 || AWVALID !== 1'b0)
            begin errors++; $display("FAIL midreset release: AWREADY=%b AWVALID=%b want 1 0", AWREADY, AWVALID); end
        bv = 1'b0;
        repeat (15) begin
            tick();
            if (BVALID !== 1'b0 || WVALID !== 1'b0) bv = 1'b1;
        end
        checks++;
        if (bv || response !== 2'b00)
            begin errors++; $display("FAIL midreset after: channel activity=%b response=%b want 0 00", bv, response); end
    endtask

    task automatic test_random;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [3:0]  len;
        logic [31:0] addr;
        for (int n = 0; n < 25; n++) begin
            burst = 2'($urandom_range(2));
            size  = 3'($urandom_range(2));
            if (burst == 2'b10) len = 4'((2 << $urandom_range(3)) - 1);
            else                len = 4'($urandom_range(15));
            addr = $urandom;
            addr = addr & ~((32'd1 << size) - 32'd1);
            run_burst($sformatf("random%0d", n), addr, len, size, burst, 30, -1, 0, 1'b0, 32'd0);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_back_to_back();
        test_held();
        test_incr_wrap();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
